camera_pattern_generator: RTL and testbench



---
 rtl/camera_pattern_pkg.sv | 51 +++++
 rtl/camera_pattern_pixel.sv | 26 ++
 rtl/camera_pattern_generator.sv | 217 +++++++++++++++++++++
 tb/tb_camera_pattern_generator.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/camera_pattern_pkg.sv
// Shared types and constants for the synthetic RAW10 camera pattern source.
// The PATTERN_FRAME_COUNTER_EN build option is implemented in the top level.
package camera_pattern_pkg;

    localparam int unsigned PIXEL_W     = 10;
    localparam int unsigned COORD_W     = 11;
    localparam int unsigned PHASE_W     = 16;
    localparam int unsigned BAR_IDX_W   = 3;
    localparam int unsigned FRAME_CNT_W = 20;

    localparam logic [PIXEL_W-1:0] PIXEL_MAX = 10'h3FF;

    typedef enum logic [1:0] {
        PATTERN_SOLID   = 2'd0,
        PATTERN_RAMP    = 2'd1,
        PATTERN_BARS    = 2'd2,
        PATTERN_CHECKER = 2'd3
    } pattern_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FV_SETUP = 3'd1,
        LINE     = 3'd2,
        HBLANK   = 3'd3,
        FV_HOLD  = 3'd4,
        VBLANK   = 3'd5
    } state_t;

    // {R,G,B} per bar, index 0 on the right: W,Y,C,G,M,R,B,K
    localparam logic [7:0][2:0] BAR_COLOUR_ROM = {
        3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111
    };

    typedef struct packed {
        logic               fv;
        logic               lv;
        logic [PIXEL_W-1:0] data;
    } pixel_beat_t;

    // RGGB: even line/even pixel is R, odd/odd is B, the rest are G
    function automatic logic bar_channel_on(input logic [2:0] rgb, input logic x0, input logic y0);
        logic on;
        case ({y0, x0})
            2'b00:   on = rgb[2];
            2'b11:   on = rgb[0];
            default: on = rgb[1];
        endcase
        return on;
    endfunction

endpackage

// File: rtl/camera_pattern_pixel.sv
// Combinational pattern pixel value for the current raster position.
module camera_pattern_pixel
    import camera_pattern_pkg::*;
(
    input  logic [PIXEL_W-1:0]   x_low,
    input  logic                 y_parity,
    input  logic                 y_bit3,
    input  logic [BAR_IDX_W-1:0] bar_idx,
    input  pattern_t             pattern,
    input  logic [PIXEL_W-1:0]   solid_value,
    output logic [PIXEL_W-1:0]   pixel_c
);

    always_comb begin
        pixel_c = '0;
        case (pattern)
            PATTERN_SOLID:   pixel_c = solid_value;
            PATTERN_RAMP:    pixel_c = x_low;
            PATTERN_BARS:    pixel_c = bar_channel_on(BAR_COLOUR_ROM[bar_idx], x_low[0], y_parity)
                                       ? PIXEL_MAX : '0;
            PATTERN_CHECKER: pixel_c = (x_low[3] ^ y_bit3) ? PIXEL_MAX : '0;
            default:         pixel_c = '0;
        endcase
    end

endmodule

// File: rtl/camera_pattern_generator.sv
// Synthetic image sensor: FV/LV timed RAW10 Bayer test patterns on the pixel clock.
// Build option PATTERN_FRAME_COUNTER_EN stamps a frame counter into line 0, pixels 0/1.
module camera_pattern_generator
    import camera_pattern_pkg::*;
#(
    parameter int unsigned IMAGE_X_SIZE = 1288,
    parameter int unsigned IMAGE_Y_SIZE = 768,
    parameter int unsigned H_BLANK      = 32,
    parameter int unsigned FV_TO_LV     = 4,
    parameter int unsigned V_BLANK      = 4096,
    parameter int unsigned BAR_WIDTH    = 161
) (
    input  logic               clock_camera_pixel,
    input  logic               reset_camera_pixel_n,
    input  logic               enable_in,
    input  logic [1:0]         pattern_select_in,
    input  logic [PIXEL_W-1:0] solid_value_in,
    output logic               pixel_fv_out,
    output logic               pixel_lv_out,
    output logic [PIXEL_W-1:0] pixel_data_out,
    output logic               frame_done_out,
    output logic               busy_out
);

    localparam logic [COORD_W-1:0]   X_LAST       = COORD_W'(IMAGE_X_SIZE - 1);
    localparam logic [COORD_W-1:0]   Y_LAST       = COORD_W'(IMAGE_Y_SIZE - 1);
    localparam logic [COORD_W-1:0]   BAR_LAST     = COORD_W'(BAR_WIDTH - 1);
    localparam logic [BAR_IDX_W-1:0] BAR_IDX_MAX  = BAR_IDX_W'(7);
    localparam logic [PHASE_W-1:0]   SETUP_LAST   = PHASE_W'(FV_TO_LV - 1);
    localparam logic [PHASE_W-1:0]   HBLANK_LAST  = PHASE_W'(H_BLANK - 1);
    localparam logic [PHASE_W-1:0]   VBLANK_LAST  = PHASE_W'(V_BLANK - 1);

    state_t               state_q,   state_n;
    logic [PHASE_W-1:0]   phase_q,   phase_n;
    logic [COORD_W-1:0]   x_q,       x_n;
    logic [COORD_W-1:0]   y_q,       y_n;
    logic [COORD_W-1:0]   bar_px_q,  bar_px_n;
    logic [BAR_IDX_W-1:0] bar_idx_q, bar_idx_n;
    pattern_t             pattern_q, pattern_n;
    logic [PIXEL_W-1:0]   solid_q,   solid_n;
    logic                 frame_done_n;
    logic                 start_frame;
    logic [PIXEL_W-1:0]   pattern_pixel_c;
    pixel_beat_t          beat_q,    beat_n;
    logic                 frame_done_q;
    logic                 busy_q;

    // Next-state and raster counters; outputs are registered from these next values
    always_comb begin
        state_n      = state_q;
        phase_n      = phase_q + PHASE_W'(1);
        x_n          = x_q;
        y_n          = y_q;
        bar_px_n     = bar_px_q;
        bar_idx_n    = bar_idx_q;
        pattern_n    = pattern_q;
        solid_n      = solid_q;
        frame_done_n = 1'b0;
        start_frame  = 1'b0;

        case (state_q)
            IDLE: begin
                phase_n = '0;
                if (enable_in) begin
                    state_n     = FV_SETUP;
                    start_frame = 1'b1;
                end
            end
            FV_SETUP: begin
                if (phase_q == SETUP_LAST) begin
                    state_n = LINE;
                    phase_n = '0;
                end
            end
            LINE: begin
                phase_n = '0;
                if (x_q == X_LAST) begin
                    x_n       = '0;
                    bar_px_n  = '0;
                    bar_idx_n = '0;
                    if (y_q == Y_LAST) begin
                        state_n = FV_HOLD;
                        y_n     = '0;
                    end else begin
                        state_n = HBLANK;
                        y_n     = y_q + COORD_W'(1);
                    end
                end else begin
                    x_n = x_q + COORD_W'(1);
                    if (bar_px_q == BAR_LAST) begin
                        bar_px_n = '0;
                        if (bar_idx_q != BAR_IDX_MAX) begin
                            bar_idx_n = bar_idx_q + BAR_IDX_W'(1);
                        end
                    end else begin
                        bar_px_n = bar_px_q + COORD_W'(1);
                    end
                end
            end
            HBLANK: begin
                if (phase_q == HBLANK_LAST) begin
                    state_n = LINE;
                    phase_n = '0;
                end
            end
            FV_HOLD: begin
                if (phase_q == SETUP_LAST) begin
                    state_n      = VBLANK;
                    phase_n      = '0;
                    frame_done_n = 1'b1;
                end
            end
            VBLANK: begin
                if (phase_q == VBLANK_LAST) begin
                    phase_n = '0;
                    if (enable_in) begin
                        state_n     = FV_SETUP;
                        start_frame = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                phase_n = '0;
            end
        endcase

        // Pattern controls are frozen for the whole frame
        if (start_frame) begin
            pattern_n = pattern_t'(pattern_select_in);
            solid_n   = solid_value_in;
            x_n       = '0;
            y_n       = '0;
            bar_px_n  = '0;
            bar_idx_n = '0;
        end
    end

    camera_pattern_pixel u_pixel (
        .x_low       (x_n[PIXEL_W-1:0]),
        .y_parity    (y_n[0]),
        .y_bit3      (y_n[3]),
        .bar_idx     (bar_idx_n),
        .pattern     (pattern_q),
        .solid_value (solid_q),
        .pixel_c     (pattern_pixel_c)
    );

`ifdef PATTERN_FRAME_COUNTER_EN
    logic [FRAME_CNT_W-1:0] frame_cnt_q;

    always_ff @(posedge clock_camera_pixel) begin
        if (!reset_camera_pixel_n) begin
            frame_cnt_q <= '0;
        end else if (frame_done_n) begin
            frame_cnt_q <= frame_cnt_q + FRAME_CNT_W'(1);
        end
    end
`endif

    // Output beat for the coming cycle; data is forced to zero outside active lines
    always_comb begin
        beat_n    = '0;
        beat_n.fv = (state_n != IDLE) && (state_n != VBLANK);
        beat_n.lv = (state_n == LINE);
`ifdef PATTERN_FRAME_COUNTER_EN
        if (!beat_n.lv) begin
            beat_n.data = '0;
        end else if ((y_n == '0) && (x_n == COORD_W'(0))) begin
            beat_n.data = frame_cnt_q[PIXEL_W-1:0];
        end else if ((y_n == '0) && (x_n == COORD_W'(1))) begin
            beat_n.data = frame_cnt_q[FRAME_CNT_W-1:PIXEL_W];
        end else begin
            beat_n.data = pattern_pixel_c;
        end
`else
        beat_n.data = beat_n.lv ? pattern_pixel_c : '0;
`endif
    end

    always_ff @(posedge clock_camera_pixel) begin
        if (!reset_camera_pixel_n) begin
            state_q      <= IDLE;
            phase_q      <= '0;
            x_q          <= '0;
            y_q          <= '0;
            bar_px_q     <= '0;
            bar_idx_q    <= '0;
            pattern_q    <= PATTERN_SOLID;
            solid_q      <= '0;
            beat_q       <= '0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_n;
            phase_q      <= phase_n;
            x_q          <= x_n;
            y_q          <= y_n;
            bar_px_q     <= bar_px_n;
            bar_idx_q    <= bar_idx_n;
            pattern_q    <= pattern_n;
            solid_q      <= solid_n;
            beat_q       <= beat_n;
            frame_done_q <= frame_done_n;
            busy_q       <= (state_n != IDLE);
        end
    end

    assign pixel_fv_out   = beat_q.fv;
    assign pixel_lv_out   = beat_q.lv;
    assign pixel_data_out = beat_q.data;
    assign frame_done_out = frame_done_q;
    assign busy_out       = busy_q;

endmodule

// File: tb/tb_camera_pattern_generator.sv
// Scoreboard bench for camera_pattern_generator with a shortened frame height.
// Expected pixels are queued per frame; a monitor pops them on every LV-high cycle.
module tb_camera_pattern_generator;

    localparam int unsigned XS     = 1288;
    localparam int unsigned YS     = 6;
    localparam int unsigned HB     = 32;
    localparam int unsigned FTL    = 4;
    localparam int unsigned VB     = 64;
    localparam int unsigned BW     = 161;
    localparam int unsigned FV_LEN = 2 * FTL + XS * YS + (YS - 1) * HB;
`ifdef PATTERN_FRAME_COUNTER_EN
    localparam bit CTR_EN = 1'b1;
`else
    localparam bit CTR_EN = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [1:0] pat;
    logic [9:0] solid;
    logic       fv;
    logic       lv;
    logic [9:0] data;
    logic       done;
    logic       busy;

    camera_pattern_generator #(
        .IMAGE_X_SIZE (XS),
        .IMAGE_Y_SIZE (YS),
        .H_BLANK      (HB),
        .FV_TO_LV     (FTL),
        .V_BLANK      (VB),
        .BAR_WIDTH    (BW)
    ) dut (
        .clock_camera_pixel   (clk),
        .reset_camera_pixel_n (rst_n),
        .enable_in            (en),
        .pattern_select_in    (pat),
        .solid_value_in       (solid),
        .pixel_fv_out         (fv),
        .pixel_lv_out         (lv),
        .pixel_data_out       (data),
        .frame_done_out       (done),
        .busy_out             (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [9:0] sb [$];
    logic [9:0] cap [0:YS-1][0:XS-1];

    int fv_rises = 0, fv_falls = 0, lv_rises = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic logic [2:0] bar_rgb(input int b);
        case (b)
            0:       return 3'b111;
            1:       return 3'b110;
            2:       return 3'b011;
            3:       return 3'b010;
            4:       return 3'b101;
            5:       return 3'b100;
            6:       return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [9:0] model_pixel(input int p, input int s, input int x, input int y, input int fidx);
        logic [9:0] v;
        logic [2:0] rgb;
        logic       on;
        int         b;
        case (p)
            0: v = 10'(s);
            1: v = 10'(x % 1024);
            2: begin
                b = x / BW;
                if (b > 7) b = 7;
                rgb = bar_rgb(b);
                if ((y % 2 == 0) && (x % 2 == 0))      on = rgb[2];
                else if ((y % 2 == 1) && (x % 2 == 1)) on = rgb[0];
                else                                   on = rgb[1];
                v = on ? 10'h3FF : 10'h000;
            end
            3: v = (((x / 8) % 2) != ((y / 8) % 2)) ? 10'h3FF : 10'h000;
            default: v = 10'h000;
        endcase
        if (CTR_EN && y == 0 && x == 0) v = 10'(fidx % 1024);
        if (CTR_EN && y == 0 && x == 1) v = 10'((fidx / 1024) % 1024);
        return v;
    endfunction

    task automatic push_frame(input int p, input int s, input int fidx);
        for (int y = 0; y < int'(YS); y++)
            for (int x = 0; x < int'(XS); x++)
                sb.push_back(model_pixel(p, s, x, y, fidx));
    endtask

    task automatic spot(input int y, input int x, input int exp);
        check($sformatf("spot_y%0d_x%0d", y, x), int'(cap[y][x]), exp);
    endtask

    task automatic wait_fv_rises(input int target);
        int n = 0;
        while (fv_rises < target && n < 20000) begin @(negedge clk); n++; end
        if (fv_rises < target) check("timeout_fv_rise", fv_rises, target);
    endtask

    task automatic wait_fv_falls(input int target);
        int n = 0;
        while (fv_falls < target && n < 20000) begin @(negedge clk); n++; end
        if (fv_falls < target) check("timeout_fv_fall", fv_falls, target);
    endtask

    task automatic wait_lv_rises(input int target);
        int n = 0;
        while (lv_rises < target && n < 20000) begin @(negedge clk); n++; end
        if (lv_rises < target) check("timeout_lv_rise", lv_rises, target);
    endtask

    task automatic wait_idle_after_fall();
        int n = 0;
        while (busy && n < 1000) begin @(negedge clk); n++; end
        check("busy_cycles_after_fv_fall", n, VB);
    endtask

    // Monitor: timing measurements and scoreboard pops, sampled 1 unit after the edge
    int  prev_fv = 0, prev_lv = 0;
    int  fv_cnt = 0, lv_cnt = 0, gap_cnt = 0, setup_cnt = 0, line_cnt = 0, vb_cnt = 0;
    bit  in_frame = 1'b0, vb_track = 1'b0;
    initial begin
        logic [9:0] exp_px;
        int         fall;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                in_frame = 1'b0;
                vb_track = 1'b0;
                prev_fv  = 0;
                prev_lv  = 0;
            end else begin
                fall = (prev_fv == 1 && !fv) ? 1 : 0;
                if (fv && prev_fv == 0) begin
                    fv_rises++;
                    if (vb_track) check("vblank_len", vb_cnt, VB);
                    vb_track  = 1'b0;
                    in_frame  = 1'b1;
                    fv_cnt    = 0;
                    setup_cnt = 0;
                    line_cnt  = 0;
                end
                if (fv) fv_cnt++;
                if (done || fall == 1) check("frame_done_on_fv_fall", int'(done), fall);
                if (lv && prev_lv == 0) begin
                    if (line_cnt == 0) check("fv_to_lv_setup", setup_cnt, FTL);
                    else               check("hblank_len", gap_cnt, HB);
                    lv_cnt = 0;
                    lv_rises++;
                end
                if (lv) begin
                    if (sb.size() == 0) begin
                        check("scoreboard_underflow", 1, 0);
                    end else begin
                        exp_px = sb.pop_front();
                        check($sformatf("pixel_y%0d_x%0d", line_cnt, lv_cnt), int'(data), int'(exp_px));
                    end
                    if (line_cnt < int'(YS) && lv_cnt < int'(XS)) cap[line_cnt][lv_cnt] = data;
                    lv_cnt++;
                end else begin
                    check("data_zero_when_lv_low", int'(data), 0);
                end
                if (!lv && prev_lv == 1) begin
                    check("line_len", lv_cnt, XS);
                    line_cnt++;
                    gap_cnt = 0;
                end
                if (fv && !lv) begin
                    gap_cnt++;
                    setup_cnt++;
                end
                if (fall == 1 && in_frame) begin
                    check("fv_high_len", fv_cnt, FV_LEN);
                    check("lines_per_frame", line_cnt, YS);
                    check("fv_hold_len", gap_cnt, FTL);
                    fv_falls++;
                    in_frame = 1'b0;
                    vb_track = 1'b1;
                    vb_cnt   = 0;
                end
                if (!fv) vb_cnt++;
                if (!busy) vb_track = 1'b0;
                prev_fv = int'(fv);
                prev_lv = int'(lv);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got %0d frames, expected 5", fv_falls);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        rst_n = 1'b0;
        en    = 1'b0;
        pat   = 2'd0;
        solid = 10'h000;
        repeat (3) @(posedge clk);
        #1;
        check("reset_fv", int'(fv), 0);
        check("reset_lv", int'(lv), 0);
        check("reset_data", int'(data), 0);
        check("reset_done", int'(done), 0);
        check("reset_busy", int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Frame 0: ramp, one cycle from enable to FV
        @(negedge clk);
        pat = 2'd1;
        push_frame(1, 0, 0);
        en = 1'b1;
        @(posedge clk);
        #1;
        check("fv_latency_from_enable", int'(fv), 1);
        check("busy_after_enable", int'(busy), 1);
        @(negedge clk);
        pat = 2'd2;
        push_frame(2, 0, 1);
        wait_fv_falls(1);
        spot(0, 1023, 1023);
        spot(0, 1024, 0);
        spot(0, 1287, 263);
        spot(2, 500, 500);
        spot(5, 7, 7);

        // Frame 1: colour bars
        wait_fv_rises(2);
        pat   = 2'd0;
        solid = 10'h155;
        push_frame(0, 'h155, 2);
        wait_fv_falls(2);
`ifdef PATTERN_FRAME_COUNTER_EN
        spot(0, 0, 1);
        spot(0, 1, 0);
`else
        spot(0, 0, 'h3FF);
        spot(0, 1, 'h3FF);
`endif
        spot(0, 160, 'h3FF);
        spot(0, 161, 'h3FF);
        spot(0, 322, 'h000);
        spot(1, 322, 'h3FF);
        spot(1, 1, 'h3FF);
        spot(1, 163, 'h000);
        spot(0, 1127, 'h000);
        spot(1, 1287, 'h000);

        // Frame 2: solid; controls changed mid-frame apply to frame 3
        wait_fv_rises(3);
        base = lv_rises;
        wait_lv_rises(base + 2);
        pat   = 2'd3;
        solid = 10'h2AA;
        push_frame(3, 'h2AA, 3);
        wait_fv_falls(3);
        spot(0, 2, 'h155);
        spot(3, 644, 'h155);
        spot(5, 1287, 'h155);

        // Frame 3: checkerboard; enable dropped mid-frame
        wait_fv_rises(4);
        base = lv_rises;
        wait_lv_rises(base + 4);
        en = 1'b0;
        wait_fv_falls(4);
        spot(0, 7, 'h000);
        spot(0, 8, 'h3FF);
        spot(0, 16, 'h000);
        spot(4, 31, 'h3FF);
        wait_idle_after_fall();
        repeat (200) @(negedge clk);
        check("no_fv_after_disable", fv_rises, 4);
        check("idle_busy_low", int'(busy), 0);

        // Frame 4 is aborted by reset during its sixth line
        pat = 2'd1;
        push_frame(1, 0, 4);
        en = 1'b1;
        wait_fv_rises(5);
        base = lv_rises;
        wait_lv_rises(base + 6);
        repeat (100) @(negedge clk);
        rst_n = 1'b0;
        en    = 1'b0;
        @(posedge clk);
        #1;
        check("midframe_reset_fv", int'(fv), 0);
        check("midframe_reset_lv", int'(lv), 0);
        check("midframe_reset_data", int'(data), 0);
        check("midframe_reset_busy", int'(busy), 0);
        check("midframe_reset_done", int'(done), 0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;

        // Restart after reset: ramp from x=0 on line 0, counter cleared
        @(negedge clk);
        pat = 2'd1;
        push_frame(1, 0, 0);
        en = 1'b1;
        @(posedge clk);
        #1;
        check("fv_latency_after_reset", int'(fv), 1);
        @(negedge clk);
        en = 1'b0;
        wait_fv_falls(5);
        spot(0, 0, 0);
        spot(0, 263, 263);
        wait_idle_after_fall();
        check("scoreboard_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
